// File: rtl/vec_scaling_pkg.sv
// Shared constants and helpers for the two-stage CORDIC gain compensation pipe.
// The rounding variant is selected with the VEC_SCALING_ROUND_EN macro.
package vec_scaling_pkg;

  localparam int NUM_SHIFTS  = 9;
  localparam int NUM_A_TERMS = 5;
  // K ~= 0.60725 as a sum of 2^-k terms; the first NUM_A_TERMS feed A, the rest feed B.
  localparam int SHIFTS [NUM_SHIFTS] = '{1, 4, 5, 7, 8, 10, 11, 12, 14};

  localparam int GUARD_BITS = 14;
  localparam int ROUND_HALF = 1 << 13;
  localparam int LATENCY    = 2;

  function automatic logic signed [63:0] sext_shr(input logic signed [63:0] x, input int k);
    return x >>> k;
  endfunction

endpackage

// File: rtl/vec_scaling_lane.sv
// One channel of gain compensation: A/B partial sums from the raw sample and the
// final add/select from the stage-1 registers. VEC_SCALING_ROUND_EN selects round half up.
module vec_scaling_lane
  import vec_scaling_pkg::*;
#(
  parameter int CORDIC_WIDTH = 22,
  parameter int SUM_W        = CORDIC_WIDTH + 1
) (
  input  logic signed [CORDIC_WIDTH-1:0] x,
  output logic signed [SUM_W-1:0]        a,
  output logic signed [SUM_W-1:0]        b,
  input  logic signed [SUM_W-1:0]        a_q,
  input  logic signed [SUM_W-1:0]        b_q,
  input  logic signed [CORDIC_WIDTH-1:0] x_q,
  input  logic                           scale_en_q,
  output logic signed [CORDIC_WIDTH-1:0] y
);

  logic signed [SUM_W-1:0]        xe;
  logic signed [SUM_W-1:0]        sum;
  logic signed [CORDIC_WIDTH-1:0] scaled;

  always_comb begin
`ifdef VEC_SCALING_ROUND_EN
    // Pre-scale so every shifted term stays exact; rounding happens once at the end.
    xe = SUM_W'(x) <<< GUARD_BITS;
`else
    xe = SUM_W'(x);
`endif
    a = '0;
    b = '0;
    for (int i = 0; i < NUM_SHIFTS; i++) begin
      if (i < NUM_A_TERMS) a = a + SUM_W'(sext_shr(64'(xe), SHIFTS[i]));
      else                 b = b + SUM_W'(sext_shr(64'(xe), SHIFTS[i]));
    end
  end

  always_comb begin
    sum = a_q + b_q;
`ifdef VEC_SCALING_ROUND_EN
    scaled = CORDIC_WIDTH'(sext_shr(64'(sum + SUM_W'(ROUND_HALF)), GUARD_BITS));
`else
    scaled = CORDIC_WIDTH'(sum);
`endif
    y = scale_en_q ? scaled : x_q;
  end

endmodule

// File: rtl/vec_scaling_pipe.sv
// Two-stage multi-channel CORDIC gain compensation (x * ~0.60725) with valid/ready
// flow control and a sideband tag. VEC_SCALING_ROUND_EN enables round-half-up arithmetic.
module vec_scaling_pipe
  import vec_scaling_pkg::*;
#(
  parameter int CORDIC_WIDTH = 22,
  parameter int NUM_CH       = 2,
  parameter int TAG_W        = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_scale_en,
  input  logic [NUM_CH*CORDIC_WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0]               in_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_CH*CORDIC_WIDTH-1:0] out_data,
  output logic [TAG_W-1:0]               out_tag
);

  localparam int W = CORDIC_WIDTH;
`ifdef VEC_SCALING_ROUND_EN
  localparam int SUM_W = W + 1 + GUARD_BITS;
`else
  localparam int SUM_W = W + 1;
`endif

  logic [NUM_CH-1:0][SUM_W-1:0] a_c, b_c, s1_a, s1_b;
  logic [NUM_CH*W-1:0]          s1_x, y_c;
  logic                         s1_valid, s1_scale;
  logic [TAG_W-1:0]             s1_tag;
  logic                         s1_load, s2_load;

  // Handshake: a beat moves on any edge where valid && ready. S2 refills when its
  // beat is taken or empty, S1 when S2 refills or S1 is empty, so bubbles collapse
  // and a full pipe streams one beat per cycle. in_ready never looks at in_valid.
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
    vec_scaling_lane #(
      .CORDIC_WIDTH (W),
      .SUM_W        (SUM_W)
    ) u_lane (
      .x          (in_data[ch*W +: W]),
      .a          (a_c[ch]),
      .b          (b_c[ch]),
      .a_q        (s1_a[ch]),
      .b_q        (s1_b[ch]),
      .x_q        (s1_x[ch*W +: W]),
      .scale_en_q (s1_scale),
      .y          (y_c[ch*W +: W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_scale <= 1'b0;
      s1_tag   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_x     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_scale <= in_scale_en;
        s1_tag   <= in_tag;
        s1_a     <= a_c;
        s1_b     <= b_c;
        s1_x     <= in_data;
      end
    end
  end

  // Data only changes when a real beat arrives, so a stalled output stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= y_c;
        out_tag  <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_vec_scaling_pipe.sv
// Self-checking bench for vec_scaling_pipe (CORDIC_WIDTH=22, NUM_CH=2, TAG_W=4).
// Honors VEC_SCALING_ROUND_EN for the rounding-dependent expectations.
module tb_vec_scaling_pipe;

  localparam int W  = 22;
  localparam int NC = 2;
  localparam int TW = 4;
  localparam int DW = NC * W;
  localparam int EW = TW + DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_scale_en;
  logic [DW-1:0] in_data;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] drv_exp;
  bit            drv_const = 1'b0;
  bit            prev_stall = 1'b0;
  logic [EW-1:0] held;
  bit            done;

  vec_scaling_pipe #(.CORDIC_WIDTH(W), .NUM_CH(NC), .TAG_W(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_scale_en (in_scale_en),
    .in_data     (in_data),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- check ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_lane(input logic [W-1:0] x, input bit se);
    int ks [9] = '{1, 4, 5, 7, 8, 10, 11, 12, 14};
    longint xs, s;
    logic [63:0] r;
    if (!se) return x;
    xs = longint'(signed'(x));
    s = 0;
`ifdef VEC_SCALING_ROUND_EN
    foreach (ks[i]) s += xs * (longint'(1) << (14 - ks[i]));
    s = (s + 8192) >>> 14;
`else
    foreach (ks[i]) s += xs >>> ks[i];
`endif
    r = s;
    return r[W-1:0];
  endfunction

  function automatic logic [EW-1:0] model_beat(input logic [DW-1:0] d, input logic [TW-1:0] t,
                                                input bit se);
    logic [DW-1:0] o;
    for (int ch = 0; ch < NC; ch++) o[ch*W +: W] = model_lane(d[ch*W +: W], se);
    return {t, o};
  endfunction

  function automatic logic [DW-1:0] pack2(input int c0, input int c1);
    logic [W-1:0] a, b;
    a = c0[W-1:0];
    b = c1[W-1:0];
    return {b, a};
  endfunction

  function automatic logic [W-1:0] rand_sample();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 5))
      0:       return 22'h200000;
      1:       return 22'h1FFFFF;
      2:       return 22'h3FFFFF;
      3:       return 22'h000000;
      default: return r[W-1:0];
    endcase
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    int occ;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      occ = exp_q.size();
      check("in_ready", in_ready, (out_valid && !out_ready && occ >= 2) ? 64'd0 : 64'd1);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {out_tag, out_data}, held);
      end
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) check("spurious_beat", out_valid, 0);
          else                   check("beat", {out_tag, out_data}, exp_q.pop_front());
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          held = {out_tag, out_data};
        end
      end else begin
        prev_stall = 1'b0;
      end
      if (in_valid && in_ready)
        exp_q.push_back(drv_const ? drv_exp : model_beat(in_data, in_tag, in_scale_en));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW-1:0] d, input logic [TW-1:0] t, input bit se);
    int n = 0;
    in_data = d;
    in_tag = t;
    in_scale_en = se;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_const(input logic [DW-1:0] d, input logic [TW-1:0] t, input bit se,
                            input logic [EW-1:0] e);
    drv_exp = e;
    drv_const = 1'b1;
    send(d, t, se);
    drv_const = 1'b0;
  endtask

  task automatic check_latency();
    @(negedge clk);
    check("lat_cycle1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_cycle2_valid", out_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_scale_en = 1'b0;
    in_data = '0;
    in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // mid-scale positive value, both channels
    send_const(pack2(1048576, 1048576), 4'h3, 1'b1, {4'h3, pack2(636736, 636736)});
    check_latency();
    drain();

    // full-scale extremes
`ifdef VEC_SCALING_ROUND_EN
    send_const(pack2(-2097152, 2097151), 4'h5, 1'b1, {4'h5, pack2(-1273472, 1273471)});
`else
    send_const(pack2(-2097152, 2097151), 4'h5, 1'b1, {4'h5, pack2(-1273472, 1273463)});
`endif
    drain();

    // -1 exposes truncation bias; 0 stays 0
`ifdef VEC_SCALING_ROUND_EN
    send_const(pack2(-1, 0), 4'h6, 1'b1, {4'h6, pack2(-1, 0)});
`else
    send_const(pack2(-1, 0), 4'h6, 1'b1, {4'h6, pack2(-9, 0)});
`endif
    drain();

    // bypass
    send_const(pack2(12345, -777), 4'hA, 1'b0, {4'hA, pack2(12345, -777)});
    check_latency();
    drain();

    // 8-beat burst with out_ready low for three cycles
    fork
      begin
        for (int i = 0; i < 8; i++) send({rand_sample(), rand_sample()}, TW'(i), 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    drain();

    // reset with two beats in flight
    send(pack2(1000, 2000), 4'h1, 1'b1);
    send(pack2(3000, 4000), 4'h2, 1'b1);
    check("rst_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_data", out_data, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_const(pack2(1048576, -2097152), 4'h7, 1'b1, {4'h7, pack2(636736, -1273472)});
    check_latency();
    drain();

    // random traffic with random back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send({rand_sample(), rand_sample()}, TW'($urandom_range(0, 15)),
               1'($urandom_range(0, 3) != 0));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #2 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
